// File: rtl/synthesijer_dotacc_pkg.sv
// Shared types and constants for the 64-bit signed dot-product accumulator.
// The saturation build option is selected by SYNTHESIJER_DOTACC_SAT_EN.
package synthesijer_dotacc_pkg;

  localparam int ACC_W = 64;

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/synthesijer_sat_add64.sv
// Combinational signed 64-bit adder with overflow flag.
// With SYNTHESIJER_DOTACC_SAT_EN defined the sum clamps on overflow.
module synthesijer_sat_add64
  import synthesijer_dotacc_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam int MSB = ACC_W - 1;

  logic [ACC_W-1:0] raw;

  always_comb begin
    raw = a + b;
    ovf = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
`ifdef SYNTHESIJER_DOTACC_SAT_EN
    // operands share a sign on overflow, so a's sign is the true sum's sign
    if (ovf) begin
      sum = a[MSB] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/synthesijer_dotacc64.sv
// Accumulates a programmed number of signed products; pulses valid at the end.
// Define SYNTHESIJER_DOTACC_SAT_EN for saturating instead of wrapping sums.
module synthesijer_dotacc64
  import synthesijer_dotacc_pkg::*;
#(
  parameter int WIDTH = ACC_W,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] prod,
  input  logic             prod_valid,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  synthesijer_sat_add64 u_add (
    .a   (acc_q),
    .b   (prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            count_d = len;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        if (prod_valid) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_ovf;
          count_d = count_q - 1'b1;
          if (count_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_ACCUM);
  assign valid    = (state_q == ST_DONE);
  assign result   = acc_q;
  assign overflow = ovf_q;

endmodule
